run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//   Synthesizable, parametrised run monitor for N_CH cores sharing one clock.
//   Counts cycles from reset release and confirms each core's halt after a
//   programmable number of stable cycles. Captures per-core halt PC and halt
//   cycle, and flags completion or a cycle-limit timeout.
//   Sits beside the CPU(s) in the top-level harness. Benches and on-chip
//   status logic read its outputs instead of polling hlt themselves.
// PARAMETERS
//   N_CH          1       number of monitored cores (>=1)
//   PC_W          16      width of each core's pc bus
//   CNT_W         32      cycle counter / capture width
//   CYCLES_LIMIT  100000  cycle count at which the run times out (1..2^CNT_W-1)
//   HALT_CONFIRM  1       consecutive hlt-high cycles needed to confirm a halt (>=1)
// PORTS
//   clk           in   1           system clock, rising edge
//   rst_n         in   1           asynchronous, active-low reset
//   hlt           in   N_CH        per-core halt request (bit i = core i)
//   pc            in   N_CH*PC_W   per-core PC, core i at [i*PC_W +: PC_W]
//   cycles        out  CNT_W       cycles elapsed since reset release
//   halted        out  N_CH        sticky per-core confirmed-halt flags
//   halt_pc       out  N_CH*PC_W   pc captured at confirm, same packing as pc
//   halt_cycle    out  N_CH*CNT_W  cycles value captured at confirm
//   done          out  1           level: run finished (all halted or timeout)
//   done_pulse    out  1           one-cycle strobe on entry to either done state
//   timeout       out  1           level: run ended by CYCLES_LIMIT
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - All outputs 0; state = RUN; all per-core confirm counters 0.
//     - Reset at any time, including mid-run or in a done state, restarts cleanly.
//   FSM: RUN -> DONE_OK | DONE_TO. Both done states are terminal until reset.
//   In RUN, at each posedge:
//     - cycles <= cycles + 1.
//     - Per core i not yet halted:
//       - hlt[i]=0: hcnt_i <= 0.
//       - hlt[i]=1 and hcnt_i < HALT_CONFIRM-1: hcnt_i <= hcnt_i + 1.
//       - hlt[i]=1 and hcnt_i == HALT_CONFIRM-1: halted[i] <= 1; halt_pc_i <= pc_i;
//         halt_cycle_i <= cycles (pre-increment value).
//     - HALT_CONFIRM=1 confirms on the first sampled hlt high.
//     - A hlt drop before confirm discards the partial count (glitch filter).
//     - Once set, halted[i] is sticky; later hlt/pc changes are ignored.
//     - If every bit of halted is 1 after this edge: state <= DONE_OK.
//     - Else if cycles == CYCLES_LIMIT-1: state <= DONE_TO; timeout <= 1.
//     - Halt wins a tie: the last core confirming on the limit edge gives
//       DONE_OK with timeout=0.
//     - Several cores may confirm on the same edge; each captures independently.
//   In DONE_OK / DONE_TO
//     - cycles, halted, halt_pc, halt_cycle, timeout are frozen.
//     - Inputs are ignored.
//   Outputs
//     - done = (state != RUN), registered.
//     - done_pulse = 1 for exactly the first cycle done is high.
//   Width rules
//     - cycles never exceeds CYCLES_LIMIT, so there is no wrap.
//     - halt_cycle < CYCLES_LIMIT always.
// TESTING (N_CH=2, PC_W=16, CYCLES_LIMIT=100, HALT_CONFIRM=2 unless noted)
//   1. Release reset, hlt=0 forever -> cycles reaches 100, timeout=1, done=1,
//      single done_pulse, halted=2'b00, cycles holds 100.
//   2. hlt[0] high cycles 10-11 (pc0=16'h0042), hlt[1] high cycles 20-21
//      (pc1=16'h0100) -> halted sets at 11/21; halt_pc={0100,0042};
//      halt_cycle={21,11}; DONE_OK, timeout=0.
//   3. hlt[0] single-cycle glitch at cycle 5, then stable from cycle 30 ->
//      no confirm at 5; confirm at cycle 31 with pc sampled at 31.
//   4. Both cores reach confirm on the edge where cycles==99 -> DONE_OK,
//      timeout=0, both halt_cycle=99.
//   5. rst_n pulsed low at cycle 50 with core 0 already halted -> all outputs 0
//      immediately (async), run restarts; then repeat scenario 2 and pass.
//   6. HALT_CONFIRM=1, N_CH=1: hlt high at cycle 0 -> halted=1 and
//      halt_cycle=0 after the first edge; done_pulse on the next cycle only.

Source files
------------

// File: rtl/run_monitor.sv
// run_monitor: watches N_CH cores sharing one clock. It counts cycles from
// reset release, confirms each core's halt after HALT_CONFIRM consecutive
// hlt-high samples, and captures the halt pc and cycle for each core. The run
// ends in DONE_OK once every core has halted, or in DONE_TO at CYCLES_LIMIT.
module run_monitor #(
    parameter int N_CH         = 1,
    parameter int PC_W         = 16,
    parameter int CNT_W        = 32,
    parameter int CYCLES_LIMIT = 100000,
    parameter int HALT_CONFIRM = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        hlt,
    input  logic [N_CH*PC_W-1:0]   pc,
    output logic [CNT_W-1:0]       cycles,
    output logic [N_CH-1:0]        halted,
    output logic [N_CH*PC_W-1:0]   halt_pc,
    output logic [N_CH*CNT_W-1:0]  halt_cycle,
    output logic                   done,
    output logic                   done_pulse,
    output logic                   timeout
);

    // The confirm counter only needs to reach HALT_CONFIRM-1.
    localparam int HC_W = (HALT_CONFIRM > 1) ? $clog2(HALT_CONFIRM) : 1;
    localparam logic [HC_W-1:0]  HC_LAST    = HC_W'(HALT_CONFIRM - 1);
    localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLES_LIMIT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE_OK = 2'd1,
        DONE_TO = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [HC_W-1:0]  hcnt [N_CH];
    logic [N_CH-1:0]  confirm;
    logic             all_halted;

    // A core confirms on this edge when its hlt run reaches the threshold.
    always_comb begin
        confirm = '0;
        for (int i = 0; i < N_CH; i++) begin
            confirm[i] = (state == RUN) && !halted[i] && hlt[i] && (hcnt[i] == HC_LAST);
        end
        all_halted = &(halted | confirm);
    end

    // Next-state decision; a halt completing on the limit edge wins over timeout.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (all_halted) begin
                    state_next = DONE_OK;
                end else if (cycles == LIMIT_LAST) begin
                    state_next = DONE_TO;
                end
            end
            DONE_OK: state_next = DONE_OK;
            DONE_TO: state_next = DONE_TO;
            default: state_next = RUN;
        endcase
    end

    // State register plus the registered done, done_pulse and timeout flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            done       <= (state_next != RUN);
            done_pulse <= (state == RUN) && (state_next != RUN);
            timeout    <= (state_next == DONE_TO);
        end
    end

    // Cycle counter runs only while the run is live, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (state == RUN) begin
            cycles <= cycles + CNT_W'(1);
        end
    end

    // Per-core glitch filter and halt capture; halted bits are sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                hcnt[i] <= '0;
            end
            halted     <= '0;
            halt_pc    <= '0;
            halt_cycle <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!halted[i]) begin
                    if (!hlt[i]) begin
                        hcnt[i] <= '0;
                    end else if (confirm[i]) begin
                        halted[i]                       <= 1'b1;
                        halt_pc[i*PC_W +: PC_W]         <= pc[i*PC_W +: PC_W];
                        halt_cycle[i*CNT_W +: CNT_W]    <= cycles;
                    end else begin
                        hcnt[i] <= hcnt[i] + HC_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: self-checking bench for run_monitor. A two-core instance
// (HALT_CONFIRM=2, limit 100) runs table-driven, hand-written and randomized
// scenarios; a single-core instance (HALT_CONFIRM=1) covers the first-edge halt.
module tb_run_monitor;

    localparam int N_CH  = 2;
    localparam int PC_W  = 16;
    localparam int CNT_W = 32;
    localparam int LIMIT = 100;
    localparam int HC    = 2;
    localparam int LEN   = LIMIT + 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       hlt;
    logic [N_CH*PC_W-1:0]  pc;
    logic [CNT_W-1:0]      cycles;
    logic [N_CH-1:0]       halted;
    logic [N_CH*PC_W-1:0]  halt_pc;
    logic [N_CH*CNT_W-1:0] halt_cycle;
    logic                  done, done_pulse, timeout;

    logic                  rst_n_s;
    logic [0:0]            hlt_s;
    logic [PC_W-1:0]       pc_s;
    logic [CNT_W-1:0]      cycles_s;
    logic [0:0]            halted_s;
    logic [PC_W-1:0]       halt_pc_s;
    logic [CNT_W-1:0]      halt_cycle_s;
    logic                  done_s, done_pulse_s, timeout_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  hlt;
        logic [15:0] pc0;
        logic [15:0] pc1;
        int          hold;
        logic [31:0] exp_cycles;
        logic [1:0]  exp_halted;
        logic        exp_done;
        logic        exp_pulse;
        logic        exp_timeout;
    } vec_t;

    vec_t s2_table [7];

    bit          hlt_seq [LEN][N_CH];
    logic [15:0] pc_seq  [LEN][N_CH];

    always #5 clk = ~clk;

    run_monitor #(
        .N_CH(N_CH), .PC_W(PC_W), .CNT_W(CNT_W),
        .CYCLES_LIMIT(LIMIT), .HALT_CONFIRM(HC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hlt(hlt), .pc(pc),
        .cycles(cycles), .halted(halted), .halt_pc(halt_pc),
        .halt_cycle(halt_cycle), .done(done), .done_pulse(done_pulse),
        .timeout(timeout)
    );

    run_monitor #(
        .N_CH(1), .PC_W(PC_W), .CNT_W(CNT_W),
        .CYCLES_LIMIT(LIMIT), .HALT_CONFIRM(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n_s), .hlt(hlt_s), .pc(pc_s),
        .cycles(cycles_s), .halted(halted_s), .halt_pc(halt_pc_s),
        .halt_cycle(halt_cycle_s), .done(done_s), .done_pulse(done_pulse_s),
        .timeout(timeout_s)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive inputs, then advance n edges; returns at a negedge for sampling.
    task automatic applyStimulus(input logic [1:0] h, input logic [15:0] p0, input logic [15:0] p1, input int n);
        hlt = h;
        pc  = {p1, p0};
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        hlt   = '0;
        pc    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runScenario2Table(input string tag);
        for (int r = 0; r < 7; r++) begin
            applyStimulus(s2_table[r].hlt, s2_table[r].pc0, s2_table[r].pc1, s2_table[r].hold);
            checkOutput($sformatf("%s_r%0d_cycles", tag, r), 64'(cycles), 64'(s2_table[r].exp_cycles));
            checkOutput($sformatf("%s_r%0d_halted", tag, r), 64'(halted), 64'(s2_table[r].exp_halted));
            checkOutput($sformatf("%s_r%0d_done", tag, r), 64'(done), 64'(s2_table[r].exp_done));
            checkOutput($sformatf("%s_r%0d_pulse", tag, r), 64'(done_pulse), 64'(s2_table[r].exp_pulse));
            checkOutput($sformatf("%s_r%0d_timeout", tag, r), 64'(timeout), 64'(s2_table[r].exp_timeout));
        end
        checkOutput({tag, "_halt_pc"}, 64'(halt_pc), 64'h0100_0042);
        checkOutput({tag, "_halt_cycle"}, 64'(halt_cycle), {32'd21, 32'd11});
    endtask

    // Randomized run: the whole input sequence is generated first, the expected
    // outcome is derived from it by searching for HC-long hlt runs, then replayed.
    task automatic randomTrial(input int trial, input int p_pct);
        int confirm [N_CH];
        int final_e;
        int max_c;
        bit all_ok;
        bit ok;
        logic [1:0]  exp_h;
        logic [31:0] exp_pc;
        logic [63:0] exp_hc;

        for (int k = 0; k < LEN; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                hlt_seq[k][i] = ($urandom_range(99) < p_pct);
                pc_seq[k][i]  = 16'($urandom);
            end
        end

        all_ok = 1'b1;
        max_c  = 0;
        for (int i = 0; i < N_CH; i++) begin
            confirm[i] = -1;
            for (int c = HC - 1; c < LIMIT && confirm[i] < 0; c++) begin
                ok = 1'b1;
                for (int j = 0; j < HC; j++) ok &= hlt_seq[c - j][i];
                if (ok) confirm[i] = c;
            end
            if (confirm[i] < 0) all_ok = 1'b0;
            else if (confirm[i] > max_c) max_c = confirm[i];
        end
        final_e = all_ok ? (max_c + 1) : LIMIT;

        resetDut();
        for (int k = 0; k < LEN; k++) begin
            applyStimulus({1'(hlt_seq[k][1]), 1'(hlt_seq[k][0])}, pc_seq[k][0], pc_seq[k][1], 1);
            for (int i = 0; i < N_CH; i++) exp_h[i] = (confirm[i] >= 0) && (confirm[i] <= k);
            checkOutput($sformatf("rnd%0d_e%0d_cycles", trial, k + 1), 64'(cycles),
                        64'((k + 1 < final_e) ? k + 1 : final_e));
            checkOutput($sformatf("rnd%0d_e%0d_halted", trial, k + 1), 64'(halted), 64'(exp_h));
            checkOutput($sformatf("rnd%0d_e%0d_done", trial, k + 1), 64'(done), 64'(k + 1 >= final_e));
            checkOutput($sformatf("rnd%0d_e%0d_pulse", trial, k + 1), 64'(done_pulse), 64'(k + 1 == final_e));
            checkOutput($sformatf("rnd%0d_e%0d_timeout", trial, k + 1), 64'(timeout),
                        64'(!all_ok && (k + 1 >= final_e)));
        end
        exp_pc = '0;
        exp_hc = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (confirm[i] >= 0) begin
                exp_pc[i*16 +: 16] = pc_seq[confirm[i]][i];
                exp_hc[i*32 +: 32] = 32'(confirm[i]);
            end
        end
        checkOutput($sformatf("rnd%0d_halt_pc", trial), 64'(halt_pc), 64'(exp_pc));
        checkOutput($sformatf("rnd%0d_halt_cycle", trial), 64'(halt_cycle), exp_hc);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int pulse_edge;
        int pcts [8] = '{0, 5, 15, 30, 45, 60, 80, 95};

        s2_table[0] = '{2'b00, 16'h0000, 16'h0000, 10, 32'd10, 2'b00, 1'b0, 1'b0, 1'b0};
        s2_table[1] = '{2'b01, 16'h0042, 16'h0000,  1, 32'd11, 2'b00, 1'b0, 1'b0, 1'b0};
        s2_table[2] = '{2'b01, 16'h0042, 16'h0000,  1, 32'd12, 2'b01, 1'b0, 1'b0, 1'b0};
        s2_table[3] = '{2'b01, 16'hFFFF, 16'h0000,  8, 32'd20, 2'b01, 1'b0, 1'b0, 1'b0};
        s2_table[4] = '{2'b10, 16'hFFFF, 16'h0100,  1, 32'd21, 2'b01, 1'b0, 1'b0, 1'b0};
        s2_table[5] = '{2'b10, 16'hFFFF, 16'h0100,  1, 32'd22, 2'b11, 1'b1, 1'b1, 1'b0};
        s2_table[6] = '{2'b11, 16'h1234, 16'h5678,  3, 32'd22, 2'b11, 1'b1, 1'b0, 1'b0};

        rst_n   = 1'b0;
        hlt     = '0;
        pc      = '0;
        rst_n_s = 1'b0;
        hlt_s   = '0;
        pc_s    = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_cycles", 64'(cycles), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_done", 64'({done, done_pulse, timeout}), 64'd0);
        checkOutput("rst_halt_pc", 64'(halt_pc), 64'd0);
        checkOutput("rst_halt_cycle", 64'(halt_cycle), 64'd0);

        // Scenario 1: no halts, run times out at the limit
        resetDut();
        pulses     = 0;
        pulse_edge = -1;
        for (int e = 1; e <= LIMIT + 10; e++) begin
            applyStimulus(2'b00, 16'h0, 16'h0, 1);
            if (done_pulse) begin
                pulses++;
                pulse_edge = e;
            end
            if (e == LIMIT - 1) begin
                checkOutput("s1_cycles_99", 64'(cycles), 64'd99);
                checkOutput("s1_done_99", 64'(done), 64'd0);
            end
        end
        checkOutput("s1_cycles", 64'(cycles), 64'd100);
        checkOutput("s1_timeout", 64'(timeout), 64'd1);
        checkOutput("s1_done", 64'(done), 64'd1);
        checkOutput("s1_halted", 64'(halted), 64'd0);
        checkOutput("s1_pulse_count", 64'(pulses), 64'd1);
        checkOutput("s1_pulse_edge", 64'(pulse_edge), 64'd100);

        // Scenario 2: staggered halts, table-driven
        resetDut();
        runScenario2Table("s2");

        // Scenario 3: single-cycle glitch is filtered, stable hlt confirms later
        resetDut();
        applyStimulus(2'b00, 16'h0, 16'h0, 5);
        applyStimulus(2'b01, 16'h0505, 16'h0, 1);
        checkOutput("s3_glitch_halted", 64'(halted), 64'd0);
        applyStimulus(2'b00, 16'h0, 16'h0, 24);
        applyStimulus(2'b01, 16'h3030, 16'h0, 1);
        checkOutput("s3_c30_halted", 64'(halted), 64'd0);
        applyStimulus(2'b01, 16'h3131, 16'h0, 1);
        checkOutput("s3_c31_halted", 64'(halted), 64'd1);
        checkOutput("s3_halt_pc0", 64'(halt_pc[15:0]), 64'h3131);
        checkOutput("s3_halt_cycle0", 64'(halt_cycle[31:0]), 64'd31);

        // Scenario 4: both cores confirm on the limit edge; halt wins
        resetDut();
        applyStimulus(2'b00, 16'h0, 16'h0, 98);
        applyStimulus(2'b11, 16'hAAAA, 16'hBBBB, 2);
        checkOutput("s4_halted", 64'(halted), 64'd3);
        checkOutput("s4_done_pulse", 64'({done, done_pulse}), 64'd3);
        checkOutput("s4_timeout", 64'(timeout), 64'd0);
        checkOutput("s4_halt_cycle", 64'(halt_cycle), {32'd99, 32'd99});
        checkOutput("s4_halt_pc", 64'(halt_pc), 64'hBBBB_AAAA);
        checkOutput("s4_cycles", 64'(cycles), 64'd100);

        // Scenario 4b: only one core confirms on the limit edge -> timeout
        resetDut();
        applyStimulus(2'b00, 16'h0, 16'h0, 98);
        applyStimulus(2'b01, 16'hCAFE, 16'h0, 2);
        checkOutput("s4b_halted", 64'(halted), 64'd1);
        checkOutput("s4b_timeout", 64'(timeout), 64'd1);
        checkOutput("s4b_halt_cycle0", 64'(halt_cycle[31:0]), 64'd99);

        // Scenario 5: async reset mid-run with a core halted, then rerun scenario 2
        resetDut();
        applyStimulus(2'b01, 16'h0007, 16'h0, 50);
        checkOutput("s5_pre_halted", 64'(halted), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_async_cycles", 64'(cycles), 64'd0);
        checkOutput("s5_async_halted", 64'(halted), 64'd0);
        checkOutput("s5_async_pc", 64'(halt_pc), 64'd0);
        checkOutput("s5_async_hc", 64'(halt_cycle), 64'd0);
        checkOutput("s5_async_flags", 64'({done, done_pulse, timeout}), 64'd0);
        hlt = '0;
        pc  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        runScenario2Table("s5");

        // Scenario 6: single core, HALT_CONFIRM=1, halt on the very first edge
        hlt_s = 1'b1;
        pc_s  = 16'h5A5A;
        @(negedge clk);
        rst_n_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("s6_halted", 64'(halted_s), 64'd1);
        checkOutput("s6_halt_cycle", 64'(halt_cycle_s), 64'd0);
        checkOutput("s6_halt_pc", 64'(halt_pc_s), 64'h5A5A);
        checkOutput("s6_done_pulse", 64'({done_s, done_pulse_s, timeout_s}), 64'b110);
        checkOutput("s6_cycles", 64'(cycles_s), 64'd1);
        hlt_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("s6_pulse_gone", 64'({done_s, done_pulse_s}), 64'b10);
        checkOutput("s6_cycles_frozen", 64'(cycles_s), 64'd1);

        // Randomized runs with varying hlt densities
        for (int t = 0; t < 8; t++) begin
            randomTrial(t, pcts[t]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
